// File: rtl/aes_pkg.sv
// Shared AES-128 constants for the inverse key schedule.
// Holds round count, FSM state encoding and the Rcon lookup.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Rcon word for round r (1..10), constant in the top byte only
    function automatic logic [31:0] rcon_word(input logic [3:0] r);
        logic [7:0] b;
        case (r)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, 24'h0};
    endfunction

endpackage

// File: rtl/subbyte.sv
// AES forward S-box for one byte.
// Built from the GF(2^8) inverse followed by the affine map.
module subbyte (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
                 ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    assign out_byte = sbox(in_byte);

endmodule

// File: rtl/inv_key_expansion.sv
// AES-128 inverse key schedule: round 10 key in, rounds 10..0 out.
// Optional macro INV_KEY_STORE_EN adds an 11-entry round-key store.
module inv_key_expansion
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
`ifdef INV_KEY_STORE_EN
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key,
`endif
    output logic [127:0] round_key,
    output logic [3:0]   round_num,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    state_t       state_q;
    state_t       state_d;
    logic [127:0] work_q;
    logic [1:0]   word_cnt_q;
    logic         load_en;
    logic         first_en;
    logic         step_en;

    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
    logic [31:0]  rot;
    logic [31:0]  sub;
    logic [31:0]  w0_new;

    assign w0 = work_q[127:96];
    assign w1 = work_q[95:64];
    assign w2 = work_q[63:32];
    assign w3 = work_q[31:0];

    // w3 is already the undone word when the w0 step runs
    assign rot    = {w3[23:0], w3[31:24]};
    assign w0_new = w0 ^ sub ^ rcon_word(round_num);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        subbyte u_sbox (
            .in_byte  (rot[31-8*i -: 8]),
            .out_byte (sub[31-8*i -: 8])
        );
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state; RUN lingers through the done cycle so start is locked out
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (round_num == 4'd0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath enables decoded from the current state
    always_comb begin
        load_en  = 1'b0;
        first_en = 1'b0;
        step_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: load_en  = start;
            ST_LOAD: first_en = 1'b1;
            ST_RUN:  step_en  = (round_num != 4'd0);
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    // Working words, published key and pulses; round_key moves only per round
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q     <= '0;
            word_cnt_q <= '0;
            round_key  <= '0;
            round_num  <= '0;
            key_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            done      <= 1'b0;
            if (load_en) work_q <= key_in;
            if (first_en) begin
                round_key  <= work_q;
                round_num  <= 4'(NUM_ROUNDS);
                key_valid  <= 1'b1;
                word_cnt_q <= '0;
            end
            if (step_en) begin
                word_cnt_q <= word_cnt_q + 2'd1;
                unique case (word_cnt_q)
                    2'd0: work_q[31:0]  <= w3 ^ w2;
                    2'd1: work_q[63:32] <= w2 ^ w1;
                    2'd2: work_q[95:64] <= w1 ^ w0;
                    2'd3: begin
                        work_q[127:96] <= w0_new;
                        round_key      <= {w0_new, work_q[95:0]};
                        round_num      <= round_num - 4'd1;
                        key_valid      <= 1'b1;
                        done           <= (round_num == 4'd1);
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef INV_KEY_STORE_EN
    logic [127:0] store_q [0:NUM_ROUNDS];

    // Capture each published key at its round index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
        end else if (key_valid) begin
            store_q[round_num] <= round_key;
        end
    end

    assign rd_key = (rd_addr <= 4'(NUM_ROUNDS)) ? store_q[rd_addr] : '0;
`endif

endmodule

// File: doc/inv_key_expansion.md
INV_KEY_EXPANSION -- requirements
Module: inv_key_expansion

Interface
REQ-001 Parameters: none; round count fixed at 10 (AES-128).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  load request; key_in is sampled on the same edge.
REQ-005 key_in  input  128  final (round-10) round key, word 0 in [127:96].
REQ-006 round_key  output  128  current decryption round key, registered.
REQ-007 round_num  output  4  round index of round_key (10 down to 0).
REQ-008 key_valid  output  1  one-cycle pulse when round_key/round_num update.
REQ-009 busy  output  1  high whenever the FSM is not IDLE.
REQ-010 done  output  1  one-cycle pulse coincident with the round-0 key_valid.

Function
REQ-011 The FSM SHALL have three states: IDLE, LOAD, RUN.
- IDLE->LOAD on start.
- LOAD->RUN unconditionally.
- RUN->IDLE after the round-0 key is produced.
REQ-012 In IDLE with start=1, the block SHALL capture key_in into the working register.
REQ-013 In LOAD, the block SHALL copy key_in to round_key, set round_num=10 and pulse key_valid, so the first key appears 1 cycle after the start edge.
REQ-014 RUN SHALL derive one 32-bit word per cycle in the order w3, w2, w1, w0, as follows:
- w3' = w3^w2
- w2' = w2^w1
- w1' = w1^w0
- w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon[r], where r is the round being undone.
REQ-015 The w0' step SHALL use the w3' value already updated in the working register.
REQ-016 round_key SHALL update only when all 4 words of a round are complete; partial words SHALL never be visible.
REQ-017 Each such update SHALL pulse key_valid and decrement round_num.
- Rounds 9..0 appear at cycles 5, 9, ..., 41 after the start edge.
- Total latency to round 0 is 41 cycles.
REQ-018 Rcon[r] for r=10..1 SHALL be 36,1b,80,40,20,10,08,04,02,01 in the top byte, zero in the other bytes.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 start asserted in the same cycle as done SHALL be ignored; a new start is accepted the following cycle.
REQ-021 After done, round_key and round_num SHALL hold (round 0 key, 0) until the next LOAD.
REQ-022 key_valid and done SHALL never be high in IDLE.

Reset
REQ-023 reset SHALL asynchronously force:
- FSM=IDLE
- round_key=0, round_num=0
- key_valid=0, busy=0, done=0
- word and round counters=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no further key_valid pulses SHALL occur until a new start.

Configuration
REQ-025 Macro INV_KEY_STORE_EN SHALL control an internal round-key store.
- Defined: adds an 11x128 register store, written at every key_valid at index round_num.
- Defined: adds input rd_addr (4 bits) and output rd_key (128 bits, combinational read).
- Defined: rd_key SHALL be 0 when rd_addr>10; reset SHALL clear the store.
- Undefined: no store, and neither port exists.

Structure
REQ-026 Shared package aes_pkg SHALL hold:
- the Rcon table
- the round count constant (10)
- the FSM state encoding.
REQ-027 SubWord SHALL use four instances of the existing subbyte S-box module; no other sub-module.

Verification
REQ-028 FIPS-197 A.1 full run:
- Stimulus: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Response: round 9 = ac7766f319fadc2128d12941575c006e.
- Response: round 0 = 2b7e151628aed2a6abf7158809cf4f3c with done at cycle 41.
REQ-029 Pulse timing: key_valid pulses exactly 11 times, at cycles 1, 5, ..., 41; round_num runs 10..0.
REQ-030 Busy lockout: start with a different key_in at cycle 20 -> ignored; outputs are identical to REQ-028.
REQ-031 Mid-run reset: reset at cycle 17 -> all outputs 0 immediately, no key_valid afterwards.
- Then start with the same key -> full correct sequence.
REQ-032 Back-to-back: start in the done cycle is ignored; start on the next cycle completes a second run correctly.
REQ-033 With INV_KEY_STORE_EN: after the REQ-028 run, rd_addr=0 -> 2b7e1516..., rd_addr=10 -> d014f9a8..., rd_addr=15 -> 0.
